// File: rtl/opl3_pkg.sv
// Shared OPL3 types: register-write transaction, host-port decode constants and host_if defaults.
package opl3_pkg;

  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;

  typedef enum logic [1:0] {
    EM_IDLE = 2'd0,
    EM_EMIT = 2'd1,
    EM_HOLD = 2'd2
  } emit_state_e;

  localparam int HOST_FIFO_DEPTH     = 16;
  localparam int HOST_MIN_WR_SPACING = 32;

  // host_address[0] selects the port within a bank
  localparam logic PORT_ADDR = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  // NEW register: the only bank-1 register reachable while in OPL2 mode
  localparam logic [7:0] NEW_REG_ADDR = 8'h05;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data; storage has no reset so it can map to RAM.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    dout_d   = dout_q;
    if (pop_ok) dout_d = mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/host_if.sv
// OPL3 host bus front end: decodes address/data port writes into a FIFO of register writes
// and emits them with a guaranteed minimum spacing; also serves the status register read.
module host_if
  import opl3_pkg::*;
#(
  parameter int FIFO_DEPTH     = HOST_FIFO_DEPTH,
  parameter int MIN_WR_SPACING = HOST_MIN_WR_SPACING
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   host_address,
  input  logic [7:0]   host_data_in,
  input  logic         host_wr,
  input  logic         host_rd,
  output logic [7:0]   host_data_out,
  output logic         host_wr_ready,
  output logic         fifo_overflow,
  input  logic         irq,
  input  logic         ft1,
  input  logic         ft2,
  output opl3_reg_wr_t opl3_reg_wr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = $clog2(MIN_WR_SPACING) + 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_WR_SPACING - 2);
  localparam bit SKIP_HOLD = (MIN_WR_SPACING == 2);

  logic [7:0]    addr_latch_q, addr_latch_d;
  logic          bank_latch_q, bank_latch_d;
  logic          new_shadow_q, new_shadow_d;
  logic [7:0]    host_data_out_q, host_data_out_d;
  logic          wr_ready_q, wr_ready_d;
  logic          fifo_overflow_q, fifo_overflow_d;
  emit_state_e   state_q, state_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  opl3_reg_wr_t  reg_wr_q, reg_wr_d;

  logic          addr_wr, data_wr, bank_eff, push, pop;
  logic          fifo_full, fifo_empty;
  logic [16:0]   fifo_din, fifo_dout;
  logic [CW-1:0] fifo_count, count_next;

  assign addr_wr  = host_wr && (host_address[0] == PORT_ADDR);
  assign data_wr  = host_wr && (host_address[0] == PORT_DATA);
  // OPL2 mode (NEW=0) folds bank-1 writes onto bank 0, except the NEW register itself
  assign bank_eff = bank_latch_q && (new_shadow_q || (addr_latch_q == NEW_REG_ADDR));
  assign push     = data_wr && !fifo_full;
  assign fifo_din = {bank_eff, addr_latch_q, host_data_in};

  sync_fifo #(
    .WIDTH (17),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    addr_latch_d    = addr_latch_q;
    bank_latch_d    = bank_latch_q;
    new_shadow_d    = new_shadow_q;
    host_data_out_d = host_data_out_q;
    fifo_overflow_d = data_wr && fifo_full;

    if (addr_wr) begin
      addr_latch_d = host_data_in;
      bank_latch_d = host_address[1];
    end
    if (push && bank_eff && (addr_latch_q == NEW_REG_ADDR)) new_shadow_d = host_data_in[0];

    if (host_rd) begin
      host_data_out_d = (host_address[0] == PORT_ADDR) ? {irq, ft1, ft2, 5'b0} : 8'h00;
    end

    count_next = fifo_count + CW'(push) - CW'(pop);
    wr_ready_d = (count_next != CW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d        = state_q;
    holdoff_d      = holdoff_q;
    pop            = 1'b0;
    reg_wr_d       = reg_wr_q;
    reg_wr_d.valid = 1'b0;

    unique case (state_q)
      EM_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = EM_EMIT;
        end
      end
      EM_EMIT: begin
        reg_wr_d.valid    = 1'b1;
        reg_wr_d.bank_num = fifo_dout[16];
        reg_wr_d.address  = fifo_dout[15:8];
        reg_wr_d.data     = fifo_dout[7:0];
        if (SKIP_HOLD) begin
          state_d = EM_IDLE;
        end else begin
          holdoff_d = HOLD_LOAD;
          state_d   = EM_HOLD;
        end
      end
      EM_HOLD: begin
        // leave when the count reaches zero so the emit-to-emit period is exactly MIN_WR_SPACING
        holdoff_d = holdoff_q - HW'(1);
        if (holdoff_q <= HW'(1)) state_d = EM_IDLE;
      end
      default: state_d = EM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_latch_q    <= '0;
      bank_latch_q    <= 1'b0;
      new_shadow_q    <= 1'b0;
      host_data_out_q <= '0;
      wr_ready_q      <= 1'b1;
      fifo_overflow_q <= 1'b0;
      state_q         <= EM_IDLE;
      holdoff_q       <= '0;
      reg_wr_q        <= '0;
    end else begin
      addr_latch_q    <= addr_latch_d;
      bank_latch_q    <= bank_latch_d;
      new_shadow_q    <= new_shadow_d;
      host_data_out_q <= host_data_out_d;
      wr_ready_q      <= wr_ready_d;
      fifo_overflow_q <= fifo_overflow_d;
      state_q         <= state_d;
      holdoff_q       <= holdoff_d;
      reg_wr_q        <= reg_wr_d;
    end
  end

  assign host_data_out = host_data_out_q;
  assign host_wr_ready = wr_ready_q;
  assign fifo_overflow = fifo_overflow_q;
  assign opl3_reg_wr   = reg_wr_q;

endmodule

// File: tb/tb_host_if.sv
// Self-checking bench for host_if: a transaction-level model (queue + pop schedule) predicts every output each cycle.
module tb_host_if;
  import opl3_pkg::*;

  localparam int DEPTH = 16;
  localparam int S     = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   host_address;
  logic [7:0]   host_data_in;
  logic         host_wr, host_rd;
  logic [7:0]   host_data_out;
  logic         host_wr_ready;
  logic         fifo_overflow;
  logic         irq = 1'b0, ft1 = 1'b0, ft2 = 1'b0;
  opl3_reg_wr_t opl3_reg_wr;

  always #5 clk = ~clk;

  host_if #(.FIFO_DEPTH(DEPTH), .MIN_WR_SPACING(S)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_address  (host_address),
    .host_data_in  (host_data_in),
    .host_wr       (host_wr),
    .host_rd       (host_rd),
    .host_data_out (host_data_out),
    .host_wr_ready (host_wr_ready),
    .fifo_overflow (fifo_overflow),
    .irq           (irq),
    .ft1           (ft1),
    .ft2           (ft2),
    .opl3_reg_wr   (opl3_reg_wr)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [16:0]  mq[$];
  logic [7:0]   m_addr;
  logic         m_bank, m_new;
  logic         pop_pend;
  logic [16:0]  pend_ent;
  longint       next_pop_ok;
  opl3_reg_wr_t exp_reg;
  logic [7:0]   exp_dout;
  longint       cyc = 0;

  // observations
  logic [16:0]  obs_ent[$];
  longint       obs_cyc[$];
  int           ovf_cnt;

  task automatic tick(input logic rst, input logic wr, input logic rd,
                      input logic [1:0] a, input logic [7:0] d);
    int   pre;
    logic beff;
    logic ovf_e;
    logic rdy_e;
    reset = rst; host_wr = wr; host_rd = rd; host_address = a; host_data_in = d;
    @(posedge clk);
    cyc++;
    ovf_e = 1'b0;
    if (rst) begin
      mq.delete();
      m_addr = 8'h00; m_bank = 1'b0; m_new = 1'b0;
      pop_pend = 1'b0; exp_reg = '0; exp_dout = 8'h00; next_pop_ok = 0;
    end else begin
      exp_reg.valid = 1'b0;
      if (pop_pend) exp_reg = {1'b1, pend_ent};
      pop_pend = 1'b0;
      pre = mq.size();
      if (pre > 0 && cyc >= next_pop_ok) begin
        pend_ent    = mq.pop_front();
        pop_pend    = 1'b1;
        next_pop_ok = cyc + S;
      end
      if (wr && a[0]) begin
        beff = m_bank && (m_new || m_addr == 8'h05);
        if (pre < DEPTH) begin
          mq.push_back({beff, m_addr, d});
          if (beff && m_addr == 8'h05) m_new = d[0];
        end else begin
          ovf_e = 1'b1;
        end
      end else if (wr) begin
        m_addr = d;
        m_bank = a[1];
      end
      if (rd) exp_dout = a[0] ? 8'h00 : {irq, ft1, ft2, 5'b0};
    end
    rdy_e = (mq.size() < DEPTH);
    #1;
    checks++;
    if (opl3_reg_wr !== exp_reg) begin
      failures++;
      $display("FAIL reg_wr cyc=%0d got=%h exp=%h", cyc, opl3_reg_wr, exp_reg);
    end
    checks++;
    if (host_wr_ready !== rdy_e) begin
      failures++;
      $display("FAIL wr_ready cyc=%0d got=%b exp=%b", cyc, host_wr_ready, rdy_e);
    end
    checks++;
    if (fifo_overflow !== ovf_e) begin
      failures++;
      $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, fifo_overflow, ovf_e);
    end
    checks++;
    if (host_data_out !== exp_dout) begin
      failures++;
      $display("FAIL data_out cyc=%0d got=%h exp=%h", cyc, host_data_out, exp_dout);
    end
    if (opl3_reg_wr.valid === 1'b1) begin
      obs_ent.push_back({opl3_reg_wr.bank_num, opl3_reg_wr.address, opl3_reg_wr.data});
      obs_cyc.push_back(cyc);
    end
    if (fifo_overflow === 1'b1) ovf_cnt++;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic clear_obs();
    obs_ent.delete();
    obs_cyc.delete();
    ovf_cnt = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (mq.size() > 0 && n < 2000) begin
      idle();
      n++;
    end
    checks++;
    if (mq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0", mq.size());
    end
    repeat (S + 2) idle();
  endtask

  task automatic test_reset();
    repeat (3) tick(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    idle();
    checks++;
    if (opl3_reg_wr !== '0 || host_data_out !== 8'h00 || host_wr_ready !== 1'b1 || fifo_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got=%h/%h/%b/%b exp=0/00/1/0",
               opl3_reg_wr, host_data_out, host_wr_ready, fifo_overflow);
    end
  endtask

  task automatic test_single_write();
    longint wcyc;
    clear_obs();
    tick(1'b0, 1'b1, 1'b0, 2'b00, 8'hA0);
    tick(1'b0, 1'b1, 1'b0, 2'b01, 8'h55);
    wcyc = cyc;
    repeat (40) idle();
    checks++;
    if (obs_ent.size() != 1) begin
      failures++;
      $display("FAIL single_count got=%0d exp=1", obs_ent.size());
    end else begin
      checks++;
      if (obs_cyc[0] != wcyc + 2) begin
        failures++;
        $display("FAIL single_latency got=%0d exp=%0d", obs_cyc[0] - wcyc, 2);
      end
      checks++;
      if (obs_ent[0] !== {1'b0, 8'hA0, 8'h55}) begin
        failures++;
        $display("FAIL single_entry got=%h exp=%h", obs_ent[0], {1'b0, 8'hA0, 8'h55});
      end
    end
  endtask

  task automatic test_bank_alias();
    logic [16:0] exp_seq[3];
    exp_seq[0] = {1'b0, 8'hC0, 8'h30};
    exp_seq[1] = {1'b1, 8'h05, 8'h01};
    exp_seq[2] = {1'b1, 8'hC0, 8'h30};
    clear_obs();
    tick(1'b0, 1'b1, 1'b0, 2'b10, 8'hC0);
    tick(1'b0, 1'b1, 1'b0, 2'b11, 8'h30);
    tick(1'b0, 1'b1, 1'b0, 2'b10, 8'h05);
    tick(1'b0, 1'b1, 1'b0, 2'b11, 8'h01);
    tick(1'b0, 1'b1, 1'b0, 2'b10, 8'hC0);
    tick(1'b0, 1'b1, 1'b0, 2'b11, 8'h30);
    drain();
    checks++;
    if (obs_ent.size() != 3) begin
      failures++;
      $display("FAIL alias_count got=%0d exp=3", obs_ent.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_ent[i] !== exp_seq[i]) begin
          failures++;
          $display("FAIL alias_entry%0d got=%h exp=%h", i, obs_ent[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic rdy[20];
    tick(1'b0, 1'b1, 1'b0, 2'b00, 8'h20);
    drain();
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 1'b0, 2'b01, 8'(i));
      rdy[i] = host_wr_ready;
    end
    drain();
    checks++;
    if (rdy[15] !== 1'b1 || rdy[16] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready got=%b%b exp=10", rdy[15], rdy[16]);
    end
    checks++;
    if (ovf_cnt != 3) begin
      failures++;
      $display("FAIL b2b_overflows got=%0d exp=3", ovf_cnt);
    end
    checks++;
    if (obs_ent.size() != 17) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=17", obs_ent.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        checks++;
        if (obs_ent[i][7:0] !== 8'(i) || obs_ent[i][15:8] !== 8'h20) begin
          failures++;
          $display("FAIL b2b_order%0d got=%h exp=%h", i, obs_ent[i][15:0], {8'h20, 8'(i)});
        end
        if (i > 0) begin
          checks++;
          if (obs_cyc[i] - obs_cyc[i-1] != S) begin
            failures++;
            $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, obs_cyc[i] - obs_cyc[i-1], S);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    longint wcyc;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 2'b01, 8'(8'h40 + i));
    repeat (6) idle();
    tick(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    clear_obs();
    repeat (80) idle();
    checks++;
    if (obs_ent.size() != 0 || host_wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_flush got=%0d/%b exp=0/1", obs_ent.size(), host_wr_ready);
    end
    tick(1'b0, 1'b1, 1'b0, 2'b01, 8'h77);
    wcyc = cyc;
    repeat (10) idle();
    checks++;
    if (obs_ent.size() != 1 || obs_cyc[0] != wcyc + 2) begin
      failures++;
      $display("FAIL reset_mid_latency got=%0d emits exp=1 at +2", obs_ent.size());
    end
    drain();
  endtask

  task automatic test_status();
    irq = 1'b1; ft1 = 1'b1; ft2 = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
    checks++;
    if (host_data_out !== 8'hC0) begin
      failures++;
      $display("FAIL status_read got=%h exp=c0", host_data_out);
    end
    tick(1'b0, 1'b0, 1'b1, 2'b01, 8'h00);
    checks++;
    if (host_data_out !== 8'h00) begin
      failures++;
      $display("FAIL data_port_read got=%h exp=00", host_data_out);
    end
    irq = 1'b0; ft1 = 1'b0; ft2 = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 2'b10, 8'h12);
    checks++;
    if (host_data_out !== 8'h20) begin
      failures++;
      $display("FAIL status_with_write got=%h exp=20", host_data_out);
    end
    ft2 = 1'b0;
    drain();
  endtask

  task automatic test_random();
    logic       wr, rd;
    logic [1:0] a;
    for (int i = 0; i < 1500; i++) begin
      irq = 1'($urandom); ft1 = 1'($urandom); ft2 = 1'($urandom);
      wr = ($urandom_range(0, 99) < 35);
      rd = ($urandom_range(0, 99) < 20);
      a  = 2'($urandom);
      tick(1'b0, wr, rd, a, 8'($urandom));
    end
    irq = 1'b0; ft1 = 1'b0; ft2 = 1'b0;
    drain();
  endtask

  initial begin
    reset = 1'b1; host_wr = 1'b0; host_rd = 1'b0; host_address = 2'b00; host_data_in = 8'h00;
    clear_obs();
    test_reset();
    test_single_write();
    test_bank_alias();
    test_back_to_back();
    test_reset_mid();
    test_status();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
